// File: rtl/axis_vec_pkg.sv
// Shared definitions for the vector <-> AXI-Stream converters.
//   a2v_state_t : state encoding of the stream-to-vector collector
//   ctr_width() : beat-counter width for an N-beat vector, at least 1 bit
package axis_vec_pkg;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } a2v_state_t;

  function automatic int ctr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_to_vector.sv
// axis_to_vector
//   Collects AXIS_BYTES-wide AXI-Stream beats into one VEC_BYTES-wide vector
//   and presents it on a valid/ready port. Packets must be exactly
//   VEC_BYTES/AXIS_BYTES beats with tlast on the final beat; malformed
//   packets are dropped and flagged with a one-cycle error pulse.
// Ports
//   clk          clock, posedge
//   aresetn      asynchronous active-low reset
//   axis_tvalid  input beat valid
//   axis_tready  input beat ready (combinational from state / vec_ready)
//   axis_tlast   last beat of packet
//   axis_tdata   beat data, AXIS_BYTES*8 bits
//   vec          assembled vector, meaningful while vec_valid=1
//   vec_valid    vector complete
//   vec_ready    consumer accepts vector
//   err_short    pulse: tlast before the vector was full
//   err_long     pulse: vector full without tlast
module axis_to_vector
  import axis_vec_pkg::*;
#(
  parameter int VEC_BYTES    = 4,
  parameter int AXIS_BYTES   = 1,
  parameter int MSB_FIRST    = 0,
  parameter int STRICT_TLAST = 1
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic                    axis_tvalid,
  output logic                    axis_tready,
  input  logic                    axis_tlast,
  input  logic [AXIS_BYTES*8-1:0] axis_tdata,
  output logic [VEC_BYTES*8-1:0]  vec,
  output logic                    vec_valid,
  input  logic                    vec_ready,
  output logic                    err_short,
  output logic                    err_long
);

  localparam int N  = VEC_BYTES / AXIS_BYTES;
  localparam int BW = AXIS_BYTES * 8;
  localparam int CW = ctr_width(N);
  localparam logic [CW-1:0] CTR_MAX = CW'(N - 1);

  if (VEC_BYTES % AXIS_BYTES != 0) begin : g_bad_ratio
    $fatal(1, "axis_to_vector: VEC_BYTES must be a multiple of AXIS_BYTES");
  end

  a2v_state_t    state;
  logic [CW-1:0] ctr;
  logic          accept;
  logic          strict_last;
  logic [CW-1:0] cur_idx;
  logic [CW-1:0] slot;

  function automatic logic [CW-1:0] slot_of(input logic [CW-1:0] b);
    return (MSB_FIRST != 0) ? CTR_MAX - b : b;
  endfunction

  // In HOLD the stream only moves when the held vector leaves in the same
  // cycle, so the next packet can start without a bubble.
  always_comb begin
    axis_tready = (state == HOLD) ? vec_ready : 1'b1;
    accept      = axis_tvalid & axis_tready;
    strict_last = (STRICT_TLAST != 0);
    // A beat accepted in HOLD is always beat 0 of the next vector.
    cur_idx     = (state == HOLD) ? '0 : ctr;
    slot        = slot_of(cur_idx);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= FILL;
      ctr       <= '0;
      vec       <= '0;
      vec_valid <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
      case (state)
        FILL, HOLD: begin
          if (accept) begin
            vec[int'(slot)*BW +: BW] <= axis_tdata;
            if (cur_idx == CTR_MAX) begin
              ctr <= '0;
              if (axis_tlast || !strict_last) begin
                state     <= HOLD;
                vec_valid <= 1'b1;
              end else begin
                state     <= DISCARD;
                vec_valid <= 1'b0;
                err_long  <= 1'b1;
              end
            end else if (axis_tlast && strict_last) begin
              ctr       <= '0;
              state     <= FILL;
              vec_valid <= 1'b0;
              err_short <= 1'b1;
            end else begin
              ctr       <= cur_idx + CW'(1);
              state     <= FILL;
              vec_valid <= 1'b0;
            end
          end else if (state == HOLD && vec_ready) begin
            state     <= FILL;
            vec_valid <= 1'b0;
          end
        end
        DISCARD: begin
          if (accept && axis_tlast) begin
            state <= FILL;
          end
        end
        default: begin
          state     <= FILL;
          ctr       <= '0;
          vec_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
